// File: rtl/sumador_serie.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flip-flop.
// Adds LSB-first, one bit per clock, then presents the registered result.
//
// Parameters:
//   N    operand/result width in bits (>=2)
// Ports:
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   inicio         in   1  start request, sampled on the rising edge
//   a, b           in   N  operands, captured when a start is accepted
//   cin            in   1  carry-in, captured when a start is accepted
//   ocupado        out  1  high while an addition is in progress
//   listo          out  1  one-cycle pulse: suma/cout just updated
//   suma           out  N  registered result, held until next completion
//   cout           out  1  registered carry-out, held with suma
//   desbordamiento out  1  signed overflow (SUMADOR_SERIE_OVF_EN only)
// Build option: define SUMADOR_SERIE_OVF_EN to add the desbordamiento output.

module sumador_serie #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         ocupado,
  output logic         listo,
  output logic [N-1:0] suma,
`ifdef SUMADOR_SERIE_OVF_EN
  output logic         cout,
  output logic         desbordamiento
`else
  output logic         cout
`endif
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    REPOSO,
    SUMANDO
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  suma_q, suma_d;
  logic          cout_q, cout_d;
  logic          listo_q, listo_d;

  logic          s_bit;
  logic          c_nxt;
  logic [N-1:0]  a_shift;

`ifdef SUMADOR_SERIE_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  // The single full-adder cell.
  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt = (a_q[0] & b_q[0]) |
                 (a_q[0] & c_q)    |
                 (b_q[0] & c_q);

  // Operand A doubles as the result shift register: each consumed
  // LSB frees the MSB slot that receives the new sum bit, so after
  // N shifts it holds the assembled sum.
  assign a_shift = {s_bit, a_q[N-1:1]};

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    a_d      = a_q;
    b_d      = b_q;
    suma_d   = suma_q;
    cout_d   = cout_q;
    listo_d  = 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (estado_q)
      REPOSO: begin
        if (inicio) begin
          a_d      = a;
          b_d      = b;
          c_d      = cin;
          cnt_d    = '0;
          estado_d = SUMANDO;
        end
      end
      SUMANDO: begin
        a_d   = a_shift;
        b_d   = b_q >> 1;
        c_d   = c_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          suma_d   = a_shift;
          cout_d   = c_nxt;
          listo_d  = 1'b1;
          estado_d = REPOSO;
`ifdef SUMADOR_SERIE_OVF_EN
          // c_q here is the carry into the MSB.
          ovf_d    = c_q ^ c_nxt;
`endif
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      suma_q   <= '0;
      cout_q   <= 1'b0;
      listo_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      a_q      <= a_d;
      b_q      <= b_d;
      suma_q   <= suma_d;
      cout_q   <= cout_d;
      listo_q  <= listo_d;
    end
  end

`ifdef SUMADOR_SERIE_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign desbordamiento = ovf_q;
`endif

  assign ocupado = (estado_q == SUMANDO);
  assign listo   = listo_q;
  assign suma    = suma_q;
  assign cout    = cout_q;

endmodule
